alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Execute-stage front end that drives the single-cycle ALU.
- Accepts decoded instruction fields from ID via valid/ready and decodes opcode/funct3/funct7 into the 4-bit ALU control code.
- Selects and conditions the operands, presents them to the ALU, then captures the ALU result into an EX/WB output register with valid/ready towards writeback.
- Two-stage pipeline, one operation per cycle, with stall and flush.

Parameters:
XLEN, 32, datapath width; the ALU is fixed at 32, so only 32 is supported.
SHAMT_W, 5, number of low operand-2 bits kept for shift operations.

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  synchronous active-low reset
flush  input  1  synchronous squash of all in-flight ops
in_valid  input  1  ID presents an op
in_ready  output  1  stage accepts the op this cycle
opcode  input  7  instruction[6:0]
funct3  input  3  instruction[14:12]
funct7  input  7  instruction[31:25]
rs1_val  input  32  source register 1 value
rs2_val  input  32  source register 2 value
imm  input  32  sign-extended I-type immediate
rd  input  5  destination register index
alu_inp1  output  32  ALU operand 1
alu_inp2  output  32  ALU operand 2
alu_control  output  4  ALU op: 0001 SLL, 0010 ADD, 0100 SUB, 0101 SLT, 0110 XOR, 0000 pass inp1
alu_result  input  32  combinational ALU result for the current alu_* outputs
out_valid  output  1  result register holds a valid op
out_ready  input  1  writeback consumes the result this cycle
out_result  output  32  captured ALU result
out_rd  output  5  destination of the captured op
out_illegal  output  1  captured op was not a supported ALU op

Behaviour:
- **Reset.** On clk with reset_n=0, both stages are cleared:
  - ex_valid=0, out_valid=0.
  - alu_inp1, alu_inp2, out_result = 0; alu_control = 0000; out_rd = 0; out_illegal = 0.
  - in_ready=0 while reset_n=0.
  - Reset mid-operation discards everything; no partial result is ever presented.
- **Stage 1 (EX register).** Drives the alu_* outputs directly from registers. Decode:
  - opcode 0110011 (R-type):
    - funct3 000: funct7 0000000 -> ADD; funct7 0100000 -> SUB.
    - funct3 001, funct7 0000000 -> SLL.
    - funct3 010, funct7 0000000 -> SLT.
    - funct3 100, funct7 0000000 -> XOR.
    - Operand 2 is rs2_val.
  - opcode 0010011 (I-type):
    - funct3 000 -> ADD; 010 -> SLT; 100 -> XOR.
    - funct3 001 with funct7 0000000 -> SLL.
    - Operand 2 is imm.
  - Anything else is illegal: alu_control=0000, illegal bit set. The op still flows through the pipe with its rd so writeback can trap.
  - For SLL only, alu_inp2 = {27'b0, op2[4:0]}. The ALU shifts by the full operand, so the issue stage performs the masking.
  - alu_inp1 = rs1_val in all cases.
- **Stage 2 (EX/WB register).**
  - When stage 1 advances, out_result <= alu_result and out_rd/out_illegal <= stage-1 copies.
  - alu_result is sampled in the same cycle the stage-1 registers drive the ALU. There is no combinational path from input ports to ALU outputs.
- **Handshake.**
  - adv2 = ex_valid & (~out_valid | out_ready)
  - in_ready = reset_n & ~flush & (~ex_valid | adv2)
  - Accept = in_valid & in_ready.
  - Latency: an op accepted in cycle N is at out_valid in cycle N+2.
  - Throughput: 1 op/cycle when out_ready=1.
- **Stall.** out_valid=1 & out_ready=0:
  - Stage 2 holds.
  - Stage 1 holds; alu_* outputs stay stable and the ALU result is recomputed identically.
  - in_ready drops when stage 1 is occupied.
- **Simultaneous events.**
  - Accept, stage-1 advance and output consumption in one cycle are all legal and all happen.
  - out_valid stays 1 continuously under back-to-back traffic.
- **Flush (priority below reset, above everything else).**
  - Next cycle ex_valid=0 and out_valid=0.
  - No input is accepted in the flush cycle.
  - Data registers may keep stale values; only the valid bits matter.
- **Output stability.** While out_valid=1 & out_ready=0, out_result, out_rd and out_illegal must not change.

Test Plan:
1. **ADD.** reset, then ADD with rs1=7, rs2=5, rd=3, out_ready=1 -> alu_control=0010 in cycle N+1; out_valid=1, out_result=12, out_rd=3 in cycle N+2.
2. **Back-to-back.** Ops in consecutive cycles: SUB 3-5, SLTI rs1=0xFFFFFFFF imm=1, XORI 0xF0^0x0F -> outputs in consecutive cycles: 0xFFFFFFFE, 1, 0xFF; in_ready held at 1.
3. **Shift masking.** SLL with rs1=1, rs2=0x00000024 -> alu_inp2=4, out_result=16; SLLI with funct7=0100000 -> out_illegal=1, alu_control=0000.
4. **Backpressure.** out_ready=0 for 3 cycles with 3 ops offered -> 2 ops accepted, then in_ready=0; out_result stable; on out_ready=1 ops drain in order with no loss or duplication.
5. **Flush.** Flush asserted with both stages full -> next cycle out_valid=0 and ex_valid=0; the op offered during the flush cycle is not accepted; the op offered in the following cycle appears 2 cycles later.
6. **Reset mid-operation.** reset_n=0 for one cycle while out_valid=1 -> all outputs at reset values the next cycle; in_ready=0 during reset, 1 after.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Execute-stage front end: decodes ID fields into ALU control/operands (stage 1),
// then captures the ALU result into the EX/WB register (stage 2) with valid/ready.
module alu_issue_stage #(
   parameter int unsigned XLEN    = 32,  // the attached ALU is fixed at 32 bits
   parameter int unsigned SHAMT_W = 5
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [6:0]      opcode,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [XLEN-1:0] imm,
   input  logic [4:0]      rd,
   output logic [XLEN-1:0] alu_inp1,
   output logic [XLEN-1:0] alu_inp2,
   output logic [3:0]      alu_control,
   input  logic [XLEN-1:0] alu_result,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [4:0]      out_rd,
   output logic            out_illegal
);

   localparam logic [6:0] OpReg = 7'b0110011;
   localparam logic [6:0] OpImm = 7'b0010011;

   localparam logic [6:0] F7Base = 7'b0000000;
   localparam logic [6:0] F7Alt  = 7'b0100000;

   localparam logic [3:0] AluPass = 4'b0000;
   localparam logic [3:0] AluSll  = 4'b0001;
   localparam logic [3:0] AluAdd  = 4'b0010;
   localparam logic [3:0] AluSub  = 4'b0100;
   localparam logic [3:0] AluSlt  = 4'b0101;
   localparam logic [3:0] AluXor  = 4'b0110;

   // Stage 1 (EX) state
   logic            ex_valid_q;
   logic [XLEN-1:0] inp1_q;
   logic [XLEN-1:0] inp2_q;
   logic [3:0]      ctrl_q;
   logic [4:0]      ex_rd_q;
   logic            ex_illegal_q;

   // Stage 2 (EX/WB) state
   logic            out_valid_q;
   logic [XLEN-1:0] out_result_q;
   logic [4:0]      out_rd_q;
   logic            out_illegal_q;

   // Decode results
   logic [3:0]      ctrl_d;
   logic            illegal_d;
   logic [XLEN-1:0] op2;
   logic [XLEN-1:0] inp2_d;

   logic adv2;
   logic accept;

   always_comb begin
      ctrl_d    = AluPass;
      illegal_d = 1'b1;
      op2       = rs2_val;
      unique case (opcode)
         OpReg: begin
            op2 = rs2_val;
            unique case (funct3)
               3'b000: begin
                  if (funct7 == F7Base) begin
                     ctrl_d    = AluAdd;
                     illegal_d = 1'b0;
                  end else if (funct7 == F7Alt) begin
                     ctrl_d    = AluSub;
                     illegal_d = 1'b0;
                  end
               end
               3'b001: begin
                  if (funct7 == F7Base) begin
                     ctrl_d    = AluSll;
                     illegal_d = 1'b0;
                  end
               end
               3'b010: begin
                  if (funct7 == F7Base) begin
                     ctrl_d    = AluSlt;
                     illegal_d = 1'b0;
                  end
               end
               3'b100: begin
                  if (funct7 == F7Base) begin
                     ctrl_d    = AluXor;
                     illegal_d = 1'b0;
                  end
               end
               default: ;
            endcase
         end
         OpImm: begin
            op2 = imm;
            unique case (funct3)
               3'b000: begin
                  ctrl_d    = AluAdd;
                  illegal_d = 1'b0;
               end
               3'b001: begin
                  if (funct7 == F7Base) begin
                     ctrl_d    = AluSll;
                     illegal_d = 1'b0;
                  end
               end
               3'b010: begin
                  ctrl_d    = AluSlt;
                  illegal_d = 1'b0;
               end
               3'b100: begin
                  ctrl_d    = AluXor;
                  illegal_d = 1'b0;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // The ALU shifts by the full operand, so the shift amount is masked here.
   always_comb begin
      inp2_d = op2;
      if (ctrl_d == AluSll) begin
         inp2_d = {{(XLEN - SHAMT_W){1'b0}}, op2[SHAMT_W-1:0]};
      end
   end

   assign adv2     = ex_valid_q & (~out_valid_q | out_ready);
   assign in_ready = reset_n & ~flush & (~ex_valid_q | adv2);
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ex_valid_q    <= 1'b0;
         inp1_q        <= '0;
         inp2_q        <= '0;
         ctrl_q        <= AluPass;
         ex_rd_q       <= '0;
         ex_illegal_q  <= 1'b0;
         out_valid_q   <= 1'b0;
         out_result_q  <= '0;
         out_rd_q      <= '0;
         out_illegal_q <= 1'b0;
      end else if (flush) begin
         // Only the valid bits are squashed; stale data is harmless.
         ex_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         if (adv2) begin
            out_valid_q   <= 1'b1;
            out_result_q  <= alu_result;
            out_rd_q      <= ex_rd_q;
            out_illegal_q <= ex_illegal_q;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end

         if (accept) begin
            ex_valid_q   <= 1'b1;
            inp1_q       <= rs1_val;
            inp2_q       <= inp2_d;
            ctrl_q       <= ctrl_d;
            ex_rd_q      <= rd;
            ex_illegal_q <= illegal_d;
         end else if (adv2) begin
            ex_valid_q <= 1'b0;
         end
      end
   end

   assign alu_inp1    = inp1_q;
   assign alu_inp2    = inp2_q;
   assign alu_control = ctrl_q;
   assign out_valid   = out_valid_q;
   assign out_result  = out_result_q;
   assign out_rd      = out_rd_q;
   assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural single-cycle ALU attached.
module tb_alu_issue_stage;

   logic        clk;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [31:0] imm;
   logic [4:0]  rd;
   logic [31:0] alu_inp1;
   logic [31:0] alu_inp2;
   logic [3:0]  alu_control;
   logic [31:0] alu_result;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [4:0]  out_rd;
   logic        out_illegal;

   int checks = 0;
   int errors = 0;

   localparam logic [6:0] OpR = 7'b0110011;
   localparam logic [6:0] OpI = 7'b0010011;

   alu_issue_stage dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .opcode      (opcode),
      .funct3      (funct3),
      .funct7      (funct7),
      .rs1_val     (rs1_val),
      .rs2_val     (rs2_val),
      .imm         (imm),
      .rd          (rd),
      .alu_inp1    (alu_inp1),
      .alu_inp2    (alu_inp2),
      .alu_control (alu_control),
      .alu_result  (alu_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_rd      (out_rd),
      .out_illegal (out_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: shifts by the full operand, as the real one does.
   always_comb begin
      alu_result = alu_inp1;
      case (alu_control)
         4'b0001: alu_result = alu_inp1 << alu_inp2;
         4'b0010: alu_result = alu_inp1 + alu_inp2;
         4'b0100: alu_result = alu_inp1 - alu_inp2;
         4'b0101: alu_result = {31'b0, $signed(alu_inp1) < $signed(alu_inp2)};
         4'b0110: alu_result = alu_inp1 ^ alu_inp2;
         default: alu_result = alu_inp1;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                        input logic [4:0] d);
      opcode   = op;
      funct3   = f3;
      funct7   = f7;
      rs1_val  = a;
      rs2_val  = b;
      imm      = im;
      rd       = d;
      in_valid = 1'b1;
      #1;
   endtask

   initial begin
      reset_n   = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      opcode    = '0;
      funct3    = '0;
      funct7    = '0;
      rs1_val   = '0;
      rs2_val   = '0;
      imm       = '0;
      rd        = '0;

      // Reset
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_alu_control", 32'(alu_control), 32'd0);
      check("rst_alu_inp1", alu_inp1, 32'd0);
      reset_n = 1'b1;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // 1. ADD 7+5 -> rd 3
      drive(OpR, 3'b000, 7'b0000000, 32'd7, 32'd5, 32'd0, 5'd3);
      tick();
      in_valid = 1'b0;
      check("add_ctrl", 32'(alu_control), 32'h2);
      check("add_inp2", alu_inp2, 32'd5);
      check("add_early_valid", 32'(out_valid), 32'd0);
      tick();
      check("add_valid", 32'(out_valid), 32'd1);
      check("add_result", out_result, 32'd12);
      check("add_rd", 32'(out_rd), 32'd3);
      tick();

      // 2. Back-to-back SUB, SLTI, XORI
      drive(OpR, 3'b000, 7'b0100000, 32'd3, 32'd5, 32'd0, 5'd1);
      check("b2b_rdy0", 32'(in_ready), 32'd1);
      tick();
      drive(OpI, 3'b010, 7'b0000000, 32'hFFFF_FFFF, 32'd0, 32'd1, 5'd2);
      check("b2b_rdy1", 32'(in_ready), 32'd1);
      tick();
      check("b2b_sub", out_result, 32'hFFFF_FFFE);
      drive(OpI, 3'b100, 7'b0000000, 32'h0000_00F0, 32'd0, 32'h0000_000F, 5'd4);
      check("b2b_rdy2", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("b2b_slti", out_result, 32'd1);
      check("b2b_slti_valid", 32'(out_valid), 32'd1);
      tick();
      check("b2b_xori", out_result, 32'h0000_00FF);
      check("b2b_xori_rd", 32'(out_rd), 32'd4);
      tick();

      // 3. Shift masking and illegal SLLI
      drive(OpR, 3'b001, 7'b0000000, 32'd1, 32'h0000_0024, 32'd0, 5'd6);
      tick();
      in_valid = 1'b0;
      check("sll_inp2", alu_inp2, 32'd4);
      check("sll_ctrl", 32'(alu_control), 32'h1);
      tick();
      check("sll_result", out_result, 32'd16);
      check("sll_illegal", 32'(out_illegal), 32'd0);
      drive(OpI, 3'b001, 7'b0100000, 32'd1, 32'd0, 32'h0000_0403, 5'd7);
      tick();
      in_valid = 1'b0;
      check("slli_bad_ctrl", 32'(alu_control), 32'h0);
      tick();
      check("slli_bad_illegal", 32'(out_illegal), 32'd1);
      check("slli_bad_rd", 32'(out_rd), 32'd7);
      tick();
      tick();
      check("drain_empty", 32'(out_valid), 32'd0);

      // 4. Backpressure
      out_ready = 1'b0;
      drive(OpR, 3'b000, 7'b0000000, 32'd100, 32'd1, 32'd0, 5'd10);
      check("bp_rdy_a", 32'(in_ready), 32'd1);
      tick();
      drive(OpR, 3'b000, 7'b0000000, 32'd200, 32'd2, 32'd0, 5'd11);
      check("bp_rdy_b", 32'(in_ready), 32'd1);
      tick();
      drive(OpR, 3'b000, 7'b0000000, 32'd300, 32'd3, 32'd0, 5'd12);
      check("bp_rdy_c", 32'(in_ready), 32'd0);
      check("bp_res_a", out_result, 32'd101);
      tick();
      check("bp_hold_res", out_result, 32'd101);
      check("bp_hold_rd", 32'(out_rd), 32'd10);
      check("bp_hold_rdy", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      #1;
      check("bp_release_rdy", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("bp_res_b", out_result, 32'd202);
      check("bp_rd_b", 32'(out_rd), 32'd11);
      tick();
      check("bp_res_c", out_result, 32'd303);
      check("bp_rd_c", 32'(out_rd), 32'd12);
      tick();
      check("bp_empty", 32'(out_valid), 32'd0);

      // 5. Flush with both stages full
      out_ready = 1'b0;
      drive(OpR, 3'b000, 7'b0000000, 32'd1, 32'd1, 32'd0, 5'd20);
      tick();
      drive(OpR, 3'b000, 7'b0000000, 32'd2, 32'd2, 32'd0, 5'd21);
      tick();
      check("fl_full", 32'(out_valid), 32'd1);
      flush = 1'b1;
      drive(OpR, 3'b000, 7'b0000000, 32'd5, 32'd5, 32'd0, 5'd22);
      check("fl_rdy", 32'(in_ready), 32'd0);
      tick();
      flush = 1'b0;
      out_ready = 1'b1;
      check("fl_out_valid", 32'(out_valid), 32'd0);
      drive(OpR, 3'b000, 7'b0000000, 32'd7, 32'd7, 32'd0, 5'd23);
      check("fl_next_rdy", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("fl_ex_empty", 32'(out_valid), 32'd0);
      tick();
      check("fl_g_valid", 32'(out_valid), 32'd1);
      check("fl_g_result", out_result, 32'd14);
      check("fl_g_rd", 32'(out_rd), 32'd23);
      tick();
      check("fl_no_ghost", 32'(out_valid), 32'd0);

      // 6. Reset mid-operation
      out_ready = 1'b0;
      drive(OpR, 3'b000, 7'b0000000, 32'd9, 32'd9, 32'd0, 5'd5);
      tick();
      drive(OpR, 3'b100, 7'b0000000, 32'd9, 32'd3, 32'd0, 5'd8);
      tick();
      in_valid = 1'b0;
      check("mr_valid", 32'(out_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      check("mr_rdy_low", 32'(in_ready), 32'd0);
      tick();
      reset_n = 1'b1;
      #1;
      check("mr_out_valid", 32'(out_valid), 32'd0);
      check("mr_out_result", out_result, 32'd0);
      check("mr_out_rd", 32'(out_rd), 32'd0);
      check("mr_out_illegal", 32'(out_illegal), 32'd0);
      check("mr_alu_inp1", alu_inp1, 32'd0);
      check("mr_alu_inp2", alu_inp2, 32'd0);
      check("mr_alu_ctrl", 32'(alu_control), 32'd0);
      check("mr_rdy_high", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      tick();
      check("mr_ex_cleared", 32'(out_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
